// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames parallel words as start/data/parity/stop
// bits, advancing one bit per baud strobe from the upstream divider.
module uart_tx_serializer #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 iClk,
   input  logic                 iReset,
   input  logic                 iBaudTick,
   input  logic [DATA_BITS-1:0] iData,
   input  logic                 iValid,
   output logic                 oReady,
   output logic                 oTx,
   output logic                 oBusy
);

   localparam int unsigned CW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 acc_q, acc_d;
   logic                 tx_q, tx_d;

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (iValid) begin
               shift_d = iData;
               acc_d   = 1'b0;
               state_d = SYNC;
            end
         end
         // SYNC waits for a strobe so the start bit is a full period wide
         SYNC: begin
            if (iBaudTick) begin
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (iBaudTick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               acc_d   = acc_q ^ shift_q[0];
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (iBaudTick) begin
               if (cnt_q == CW'(DATA_BITS - 1)) begin
                  cnt_d = '0;
                  if (PARITY != 0) begin
                     state_d = PAR;
                     tx_d    = (PARITY == 1) ? acc_q : ~acc_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shift_d = shift_q >> 1;
                  cnt_d   = cnt_q + CW'(1);
                  tx_d    = shift_q[1];
                  acc_d   = acc_q ^ shift_q[1];
               end
            end
         end
         PAR: begin
            if (iBaudTick) begin
               state_d = STOP;
               tx_d    = 1'b1;
               cnt_d   = '0;
            end
         end
         STOP: begin
            if (iBaudTick) begin
               if (cnt_q == CW'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign oReady = (state_q == IDLE);
   assign oBusy  = (state_q != IDLE);
   assign oTx    = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four parameter variants sharing
// clock, reset, strobe and data, each with its own valid line.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] dat = 8'h00;
   logic       vld [4];
   logic       rdy [4];
   logic       tx  [4];
   logic       bsy [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (15) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .iClk(clk), .iReset(rst), .iBaudTick(tick), .iData(dat),
      .iValid(vld[0]), .oReady(rdy[0]), .oTx(tx[0]), .oBusy(bsy[0]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
      .iClk(clk), .iReset(rst), .iBaudTick(tick), .iData(dat),
      .iValid(vld[1]), .oReady(rdy[1]), .oTx(tx[1]), .oBusy(bsy[1]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
      .iClk(clk), .iReset(rst), .iBaudTick(tick), .iData(dat),
      .iValid(vld[2]), .oReady(rdy[2]), .oTx(tx[2]), .oBusy(bsy[2]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
      .iClk(clk), .iReset(rst), .iBaudTick(tick), .iData(dat),
      .iValid(vld[3]), .oReady(rdy[3]), .oTx(tx[3]), .oBusy(bsy[3]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      int c;
      c = 0;
      do begin
         @(posedge clk);
         c++;
      end while (!tick && c < 40);
      if (!tick) begin
         n_vec++;
         n_err++;
         $error("FAIL tick_timeout: observed no strobe expected one");
      end
   endtask

   task automatic accept(input int u, input logic [7:0] d);
      @(negedge clk);
      dat = d;
      vld[u] = 1'b1;
      @(posedge clk);
      #1;
      vld[u] = 1'b0;
      chk($sformatf("u%0d_acc_rdy", u), rdy[u], 1'b0);
      chk($sformatf("u%0d_acc_bsy", u), bsy[u], 1'b1);
      chk($sformatf("u%0d_sync_tx", u), tx[u], 1'b1);
   endtask

   // early_k >= 0 raises valid with nd during that bit; the bench then
   // expects nd to be accepted the cycle after ready returns
   task automatic run_frame(input int u, input logic [7:0] d,
                            input bit haspar, input logic pbit,
                            input int ns, input int early_k,
                            input logic [7:0] nd);
      logic [11:0] bits;
      int n;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      n = 9;
      if (haspar) begin
         bits[n] = pbit;
         n++;
      end
      n += ns;
      for (int k = 0; k < n; k++) begin
         wait_tick();
         #1;
         chk($sformatf("u%0d_%02h_bit%0d", u, d, k), tx[u], bits[k]);
         chk($sformatf("u%0d_%02h_bsy%0d", u, d, k), bsy[u], 1'b1);
         if (k == early_k) begin
            dat = nd;
            vld[u] = 1'b1;
         end
         repeat (8) @(negedge clk);
         chk($sformatf("u%0d_%02h_mid%0d", u, d, k), tx[u], bits[k]);
      end
      wait_tick();
      #1;
      chk($sformatf("u%0d_%02h_end_rdy", u, d), rdy[u], 1'b1);
      chk($sformatf("u%0d_%02h_end_bsy", u, d), bsy[u], 1'b0);
      chk($sformatf("u%0d_%02h_end_tx", u, d), tx[u], 1'b1);
      if (early_k >= 0) begin
         @(posedge clk);
         #1;
         vld[u] = 1'b0;
         chk($sformatf("u%0d_chain_rdy", u), rdy[u], 1'b0);
         chk($sformatf("u%0d_chain_bsy", u), bsy[u], 1'b1);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) vld[i] = 1'b0;

      // reset values
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_tx%0d", i), tx[i], 1'b1);
         chk($sformatf("rst_rdy%0d", i), rdy[i], 1'b1);
         chk($sformatf("rst_bsy%0d", i), bsy[i], 1'b0);
      end
      rst = 1'b0;

      // idle with strobes running and no valid
      for (int i = 0; i < 10; i++) begin
         repeat (20) @(negedge clk);
         chk("idle_tx", tx[0], 1'b1);
         chk("idle_rdy", rdy[0], 1'b1);
         chk("idle_bsy", bsy[0], 1'b0);
      end

      // 8N1 0x55
      accept(0, 8'h55);
      run_frame(0, 8'h55, 1'b0, 1'b0, 1, -1, 8'h00);

      // 0x07 even parity -> 1, odd parity -> 0
      accept(1, 8'h07);
      run_frame(1, 8'h07, 1'b1, 1'b1, 1, -1, 8'h00);
      accept(2, 8'h07);
      run_frame(2, 8'h07, 1'b1, 1'b0, 1, -1, 8'h00);

      // two stop bits, 0x00 then 0xFF held valid back to back
      accept(3, 8'h00);
      run_frame(3, 8'h00, 1'b0, 1'b0, 2, 10, 8'hFF);
      run_frame(3, 8'hFF, 1'b0, 1'b0, 2, -1, 8'h00);

      // 0x12 offered while busy with 0x5A is held off until ready
      accept(0, 8'h5A);
      run_frame(0, 8'h5A, 1'b0, 1'b0, 1, 3, 8'h12);
      run_frame(0, 8'h12, 1'b0, 1'b0, 1, -1, 8'h00);

      // reset during data bit 3 of 0xA3
      accept(0, 8'hA3);
      repeat (5) wait_tick();
      #1;
      chk("a3_bit3", tx[0], 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_tx", tx[0], 1'b1);
      chk("abort_rdy", rdy[0], 1'b1);
      chk("abort_bsy", bsy[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      wait_tick();
      #1;
      chk("post_rst_tx", tx[0], 1'b1);
      chk("post_rst_rdy", rdy[0], 1'b1);
      accept(0, 8'h3C);
      run_frame(0, 8'h3C, 1'b0, 1'b0, 1, -1, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
